// File: rtl/demux_pkg.sv
// Shared constants and helpers for the four-lane word demultiplexer.
package demux_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int N_LANES    = 4;
    localparam int SEL_W      = 2;

    typedef logic [SEL_W-1:0]   lane_sel_t;
    typedef logic [N_LANES-1:0] lane_mask_t;

    // Bit k of the result is set when sel addresses lane k.
    function automatic lane_mask_t lane_onehot(input lane_sel_t sel);
        lane_mask_t mask;
        case (sel)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry lane register: load wins over drain, reset clears flag and word.
module demux_lane
    import demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data
);

    logic              valid_q;
    logic              valid_d;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] data_d;

    // Next-state: a load replaces the entry even when it is drained the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Lane state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/word_demux4.sv
// Routes one upstream word per cycle into one of four one-entry lanes.
// Optional broadcast mode (all lanes at once) is enabled by WORD_DEMUX_BCAST_EN.
module word_demux4
    import demux_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic [WORD_W-1:0]  i_val,
`ifdef WORD_DEMUX_BCAST_EN
    input  logic               i_bcast,
`endif
    output logic [N_LANES-1:0] o_valid,
    output logic [WORD_W-1:0]  o_val0,
    output logic [WORD_W-1:0]  o_val1,
    output logic [WORD_W-1:0]  o_val2,
    output logic [WORD_W-1:0]  o_val3,
    input  logic [N_LANES-1:0] i_ready
);

    // Internally bit k is lane k; on the ports lane 0 sits in the MSB.
    lane_mask_t        lane_valid_s;
    lane_mask_t        lane_ready_s;
    lane_mask_t        lane_free_s;
    lane_mask_t        lane_tgt_s;
    lane_mask_t        lane_load_s;
    lane_mask_t        lane_drain_s;
    lane_mask_t        sel_onehot_s;
    logic              ready_s;
    logic              accept_s;
    logic [WORD_W-1:0] lane_data_s [N_LANES];

    for (genvar k = 0; k < N_LANES; k++) begin : g_map
        assign lane_ready_s[k]           = i_ready[N_LANES-1-k];
        assign o_valid[N_LANES-1-k]      = lane_valid_s[k];
    end

    assign sel_onehot_s = lane_onehot(i_sel);
    assign lane_free_s  = ~lane_valid_s | lane_ready_s;

    // Upstream handshake and per-lane target selection; never depends on i_valid.
    always_comb begin
        lane_tgt_s = sel_onehot_s;
        ready_s    = |(sel_onehot_s & lane_free_s);
`ifdef WORD_DEMUX_BCAST_EN
        if (i_bcast) begin
            lane_tgt_s = '1;
            ready_s    = &lane_free_s;
        end else begin
            lane_tgt_s = sel_onehot_s;
            ready_s    = |(sel_onehot_s & lane_free_s);
        end
`endif
    end

    // Nothing is loaded on a reset edge, even though o_ready stays high.
    assign accept_s     = i_valid & ready_s & ~i_rst;
    assign lane_load_s  = lane_tgt_s & {N_LANES{accept_s}};
    assign lane_drain_s = lane_valid_s & lane_ready_s;
    assign o_ready      = ready_s;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        demux_lane #(
            .WORD_W (WORD_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (lane_load_s[k]),
            .i_drain (lane_drain_s[k]),
            .i_data  (i_val),
            .o_valid (lane_valid_s[k]),
            .o_data  (lane_data_s[k])
        );
    end

    assign o_val0 = lane_data_s[0];
    assign o_val1 = lane_data_s[1];
    assign o_val2 = lane_data_s[2];
    assign o_val3 = lane_data_s[3];

endmodule

// File: tb/tb_word_demux4.sv
// Self-checking bench for word_demux4: directed scenarios plus random traffic
// checked against a per-lane queue model (broadcast under WORD_DEMUX_BCAST_EN).
module tb_word_demux4;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [1:0]   i_sel;
    logic [W-1:0] i_val;
    logic [3:0]   o_valid;
    logic [W-1:0] o_val0, o_val1, o_val2, o_val3;
    logic [3:0]   i_ready;
`ifdef WORD_DEMUX_BCAST_EN
    logic         i_bcast = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int lane0_outs = 0;
    logic [W-1:0] mq [4][$];

    word_demux4 #(.WORD_W(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sel   (i_sel),
        .i_val   (i_val),
`ifdef WORD_DEMUX_BCAST_EN
        .i_bcast (i_bcast),
`endif
        .o_valid (o_valid),
        .o_val0  (o_val0),
        .o_val1  (o_val1),
        .o_val2  (o_val2),
        .o_val3  (o_val3),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_val(input int k);
        case (k)
            0:       return o_val0;
            1:       return o_val1;
            2:       return o_val2;
            default: return o_val3;
        endcase
    endfunction

    // Port vectors put lane 0 in the MSB.
    function automatic logic lane_rdy(input int k);
        return i_ready[3-k];
    endfunction

    function automatic logic lane_vld(input int k);
        return o_valid[3-k];
    endfunction

    function automatic bit bcast_on();
`ifdef WORD_DEMUX_BCAST_EN
        return i_bcast;
`else
        return 1'b0;
`endif
    endfunction

    // Check outputs against the queue model, then clock one edge and update it.
    task automatic cycle();
        bit exp_rdy;
        bit tin;
        bit pop [4];
        int s;
        #1;
        s = int'(i_sel);
        if (bcast_on()) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++)
                if (mq[k].size() != 0 && !lane_rdy(k)) exp_rdy = 1'b0;
        end else begin
            exp_rdy = (mq[s].size() == 0) || lane_rdy(s);
        end
        chk("o_ready", 32'(o_ready), 32'(exp_rdy));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("o_valid_lane%0d", k), 32'(lane_vld(k)), 32'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                chk($sformatf("o_val_lane%0d", k), 32'(lane_val(k)), 32'(mq[k][0]));
            pop[k] = (mq[k].size() != 0) && lane_rdy(k);
        end
        tin = i_valid && exp_rdy && !i_rst;
        @(posedge i_clk);
        if (i_rst) begin
            for (int k = 0; k < 4; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop[k]) begin
                    void'(mq[k].pop_front());
                    if (k == 0) lane0_outs++;
                end
            end
            if (tin) begin
                if (bcast_on()) begin
                    for (int k = 0; k < 4; k++) mq[k].push_back(i_val);
                end else begin
                    mq[s].push_back(i_val);
                end
            end
        end
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'(4'b0000));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_val%0d", tag, k), 32'(lane_val(k)), 32'(16'h0000));
    endtask

    initial begin
        int base;

        // Reset with a word offered: nothing may load.
        i_rst = 1'b1; i_valid = 1'b1; i_sel = 2'd2; i_val = 16'h1234; i_ready = 4'b0000;
        @(posedge i_clk); #1;
        cycle();
        cycle();
        i_rst = 1'b0; i_valid = 1'b0;
        #1;
        chk_all_zero("reset");
        chk("reset_ready", 32'(o_ready), 32'(1'b1));

        // Single route into lane 2, held while the consumer stalls.
        i_sel = 2'd2; i_val = 16'hA5C3; i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            i_sel = 2'($urandom); i_val = 16'($urandom);
            cycle();
            chk("hold_valid", 32'(o_valid), 32'(4'b0010));
            chk("hold_val2", 32'(o_val2), 32'(16'hA5C3));
        end

        // Backpressure on lane 1, then retarget to lane 3.
        i_sel = 2'd1; i_val = 16'h1111; i_valid = 1'b1;
        cycle();
        i_val = 16'h3333;
        #1;
        chk("bp_ready_full", 32'(o_ready), 32'(1'b0));
        cycle();
        i_sel = 2'd3;
        #1;
        chk("bp_ready_retarget", 32'(o_ready), 32'(1'b1));
        cycle();
        i_valid = 1'b0;
        chk("bp_valid", 32'(o_valid), 32'(4'b0111));
        chk("bp_val3", 32'(o_val3), 32'(16'h3333));
        chk("bp_val1", 32'(o_val1), 32'(16'h1111));

        // Drain everything, then stream 8 words through lane 0.
        i_ready = 4'b1111;
        cycle();
        i_ready = 4'b1000; i_sel = 2'd0;
        base = lane0_outs;
        for (int w = 1; w <= 8; w++) begin
            i_val = 16'(w); i_valid = 1'b1;
            #1;
            chk("tp_ready", 32'(o_ready), 32'(1'b1));
            cycle();
            chk("tp_lane0_valid", 32'(o_valid[3]), 32'(1'b1));
            chk("tp_lane0_word", 32'(o_val0), 32'(w));
        end
        i_valid = 1'b0;
        cycle();
        chk("tp_outs", 32'(lane0_outs - base), 32'd8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            i_rst   = ($urandom_range(0, 49) == 0);
            i_valid = 1'($urandom);
            i_sel   = 2'($urandom);
            i_val   = 16'($urandom);
            i_ready = 4'($urandom);
`ifdef WORD_DEMUX_BCAST_EN
            i_bcast = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end
        i_rst = 1'b0; i_valid = 1'b0;
`ifdef WORD_DEMUX_BCAST_EN
        i_bcast = 1'b0;
`endif

        // Reset in the middle of operation with all lanes full.
        i_ready = 4'b1111;
        cycle();
        i_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            i_sel = 2'(k); i_val = 16'hC000 + 16'(k); i_valid = 1'b1;
            cycle();
        end
        chk("mid_full", 32'(o_valid), 32'(4'b1111));
        i_rst = 1'b1; i_sel = 2'd1; i_val = 16'hDEAD;
        cycle();
        i_rst = 1'b0; i_valid = 1'b0;
        chk_all_zero("mid_reset");
        i_ready = 4'b1111;
        for (int i = 0; i < 3; i++) cycle();

`ifdef WORD_DEMUX_BCAST_EN
        // Broadcast waits for every lane, then fills all four.
        i_ready = 4'b0000; i_sel = 2'd0; i_val = 16'h0F0F; i_valid = 1'b1;
        cycle();
        i_bcast = 1'b1; i_sel = 2'd2; i_val = 16'hBEEF;
        #1;
        chk("bc_ready_blocked", 32'(o_ready), 32'(1'b0));
        cycle();
        i_ready = 4'b1000;
        #1;
        chk("bc_ready_open", 32'(o_ready), 32'(1'b1));
        cycle();
        i_valid = 1'b0; i_bcast = 1'b0; i_ready = 4'b0000;
        chk("bc_valid", 32'(o_valid), 32'(4'b1111));
        for (int k = 0; k < 4; k++)
            chk($sformatf("bc_val%0d", k), 32'(lane_val(k)), 32'(16'hBEEF));
        cycle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_demux4.md
WORD_DEMUX4 -- requirements
Module: word_demux4

Interface
REQ-001 SHALL have parameter WORD_W, default 16, data word width in bits.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  upstream word present.
REQ-005 SHALL have port o_ready  output  1  block accepts the upstream word this cycle.
REQ-006 SHALL have port i_sel  input  2 ([0:1], bit 0 MSB)  destination lane index 0..3.
REQ-007 SHALL have port i_val  input  WORD_W ([0:WORD_W-1])  upstream data word.
REQ-008 SHALL have port o_valid  output  4 ([0:3])  bit k: lane k holds a word.
REQ-009 SHALL have ports o_val0..o_val3  output  WORD_W each  lane k held word.
REQ-010 SHALL have port i_ready  input  4 ([0:3])  bit k: lane k consumer takes word.

Function
REQ-011 SHALL implement four independent one-entry lane registers, each with a valid flag and a data word.
REQ-012 SHALL define lane k transfer-out as o_valid[k] && i_ready[k] on a rising edge.
REQ-013 SHALL drive o_ready = !o_valid[i_sel] || i_ready[i_sel], combinationally; o_ready SHALL NOT depend on i_valid.
REQ-014 SHALL define transfer-in as i_valid && o_ready; on transfer-in, lane i_sel loads i_val and sets valid at the next edge (latency 1 cycle).
REQ-015 SHALL, for a lane that is full and drained in the same cycle as a transfer-in to it, load the new word and keep valid = 1 (full-throughput, one word per cycle per lane).
REQ-016 SHALL clear lane k valid after transfer-out when no transfer-in targets lane k that cycle.
REQ-017 SHALL leave non-selected lanes unchanged except for their own transfer-out.
REQ-018 SHALL hold o_valN stable while o_valid[N] = 1 and i_ready[N] = 0.
REQ-019 SHALL ignore i_sel and i_val when i_valid = 0; changing i_sel while i_valid = 1 and o_ready = 0 is legal and retargets the request.
REQ-020 SHALL ignore i_ready[k] while o_valid[k] = 0.
REQ-021 SHALL never drop or duplicate a word: every transfer-in produces exactly one transfer-out on lane i_sel.

Reset
REQ-022 SHALL, while i_rst = 1 at a rising edge, clear all o_valid bits to 0 and all o_valN to 0, discarding held words.
REQ-023 SHALL drive o_ready per REQ-013 during reset (lanes empty, so o_ready = 1), but SHALL NOT load any word on an edge where i_rst = 1.

Configuration
REQ-024 SHALL, with WORD_DEMUX_BCAST_EN defined, add port i_bcast input 1; when i_bcast = 1, o_ready = AND over k of (!o_valid[k] || i_ready[k]), and transfer-in loads i_val into all four lanes simultaneously, ignoring i_sel.
REQ-025 SHALL, without WORD_DEMUX_BCAST_EN, omit port i_bcast and behave exactly per REQ-013..021.

Structure
REQ-026 SHALL take WORD_W default, lane count (4) and select width (2) from shared package demux_pkg.
REQ-027 SHALL instantiate sub-module demux_lane (one-entry valid/data register with load, drain, and reset) four times.

Verification
REQ-028 Reset: assert i_rst 2 cycles with i_valid = 1 -> o_valid = 0000, all o_valN = 0000h, o_ready = 1, no load.
REQ-029 Single route: i_sel = 2, i_val = A5C3h, i_valid 1 cycle, i_ready = 0000 -> next cycle o_valid = 0010, o_val2 = A5C3h, held stable 10 cycles.
REQ-030 Backpressure: lane 1 full, i_ready[1] = 0, i_sel = 1, i_valid = 1 -> o_ready = 0; switch i_sel = 3 -> o_ready = 1, word lands in lane 3 only.
REQ-031 Throughput: i_sel = 0, i_ready[0] = 1, words 0001h..0008h on 8 consecutive cycles -> o_ready constant 1, 8 transfer-outs in order, no gaps.
REQ-032 Reset mid-operation: all four lanes full, i_rst 1 cycle -> o_valid = 0000 next cycle, held words never appear.
REQ-033 Broadcast (WORD_DEMUX_BCAST_EN): lane 0 full, i_ready[0] = 0, i_bcast = 1 -> o_ready = 0; raise i_ready[0] -> BEEFh loads all lanes, o_valid = 1111.
